// File: rtl/alu_matrix_pkg.sv
// Shared encodings and types for the 2x2 matrix ALU: command classes,
// compute opcodes, read-source selectors and the packed matrix type.
package alu_matrix_pkg;

    localparam int MAT_DW = 32;

    // Element index is row*2 + col; element 0 sits in the low DW bits.
    typedef logic [3:0][MAT_DW-1:0] mat_t;

    typedef enum logic [1:0] {
        CLS_WRA = 2'b00,
        CLS_WRB = 2'b01,
        CLS_OP  = 2'b10,
        CLS_RD  = 2'b11
    } cls_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_MMUL = 4'd3,
        OP_EMUL = 4'd4,
        OP_TRN  = 4'd5,
        OP_SMUL = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        SRC_C    = 2'b00,
        SRC_A    = 2'b01,
        SRC_B    = 2'b10,
        SRC_ZERO = 2'b11
    } src_e;

endpackage

// File: rtl/alu_matrix_if.sv
// Command/read-back bundle of the matrix ALU: a master drives commands,
// the slave returns the registered element.
interface alu_matrix_if #(
    parameter int DW = 32
);
    logic [5:0]    sel;
    logic [DW-1:0] ele_in;
    logic [DW-1:0] ele_out;

    modport master (output sel, output ele_in, input ele_out);
    modport slave  (input sel, input ele_in, output ele_out);
endinterface

// File: rtl/alu_matrix_core.sv
// Purely combinational 2x2 matrix datapath: produces the next C and a load
// strobe that is low for NOP opcodes so C keeps its value.
module alu_matrix_core
    import alu_matrix_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0][DW-1:0] a,
    input  logic [3:0][DW-1:0] b,
    input  logic [DW-1:0]      scalar,
    input  logic [3:0]         opcode,
    output logic [3:0][DW-1:0] c_next,
    output logic               c_load
);

    logic [3:0][DW-1:0] sum_w;
    logic [3:0][DW-1:0] diff_w;
    logic [3:0][DW-1:0] mmul_w;
    logic [3:0][DW-1:0] emul_w;
    logic [3:0][DW-1:0] trn_w;
    logic [3:0][DW-1:0] smul_w;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elem
            localparam int R = gi / 2;
            localparam int K = gi % 2;
            // All products and partial sums are DW wide, so they wrap modulo 2^DW.
            assign sum_w[gi]  = a[gi] + b[gi];
            assign diff_w[gi] = a[gi] - b[gi];
            assign mmul_w[gi] = a[R*2] * b[K] + a[R*2+1] * b[2+K];
            assign emul_w[gi] = a[gi] * b[gi];
            assign trn_w[gi]  = a[K*2+R];
            assign smul_w[gi] = scalar * a[gi];
        end
    endgenerate

    always_comb begin
        c_next = '0;
        c_load = 1'b1;
        case (opcode)
            OP_ADD:  c_next = sum_w;
            OP_SUB:  c_next = diff_w;
            OP_MMUL: c_next = mmul_w;
            OP_EMUL: c_next = emul_w;
            OP_TRN:  c_next = trn_w;
            OP_SMUL: c_next = smul_w;
            OP_AND:  c_next = a & b;
            OP_OR:   c_next = a | b;
            OP_XOR:  c_next = a ^ b;
            default: c_load = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_matrix_top.sv
// 2x2 matrix ALU: holds matrices A, B, C, decodes one command per clock and
// returns a registered element on eleOut.
module alu_matrix_top
    import alu_matrix_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    sel,
    input  logic [DW-1:0] eleIn,
    output logic [DW-1:0] eleOut
);

    logic [3:0][DW-1:0] a_reg;
    logic [3:0][DW-1:0] b_reg;
    logic [3:0][DW-1:0] c_reg;
    logic [3:0][DW-1:0] c_next;
    logic               c_load;
    logic [DW-1:0]      ele_out_reg;
    logic [DW-1:0]      rd_next;
    cls_e               cls;
    logic [1:0]         idx;

    assign cls = cls_e'(sel[5:4]);
    assign idx = sel[1:0];

    alu_matrix_core #(.DW(DW)) u_core (
        .a      (a_reg),
        .b      (b_reg),
        .scalar (eleIn),
        .opcode (sel[3:0]),
        .c_next (c_next),
        .c_load (c_load)
    );

    // Read mux sees register contents only, so there is no same-cycle bypass.
    always_comb begin
        rd_next = '0;
        case (sel[3:2])
            SRC_C:   rd_next = c_reg[idx];
            SRC_A:   rd_next = a_reg[idx];
            SRC_B:   rd_next = b_reg[idx];
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            ele_out_reg <= '0;
        end else begin
            case (cls)
                CLS_WRA: a_reg[idx] <= eleIn;
                CLS_WRB: b_reg[idx] <= eleIn;
                CLS_OP:  if (c_load) c_reg <= c_next;
                CLS_RD:  ele_out_reg <= rd_next;
            endcase
        end
    end

    assign eleOut = ele_out_reg;

endmodule

// File: tb/tb_alu_matrix_top.sv
// Randomised bench for alu_matrix_top: a 2x2 matrix model tracks A/B/C and
// the expected read-back, checked every cycle, plus literal directed checks.
module tb_alu_matrix_top;

    logic clk = 1'b0;
    logic reset;
    bit   started = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    alu_matrix_if #(.DW(32)) bus ();

    alu_matrix_top #(.DW(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (bus.sel),
        .eleIn  (bus.ele_in),
        .eleOut (bus.ele_out)
    );

    always #5 clk = ~clk;

    logic [31:0] ma [2][2];
    logic [31:0] mb [2][2];
    logic [31:0] mc [2][2];
    logic [31:0] mout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
                mc[r][c] = '0;
            end
        mout = '0;
    endtask

    // One command applied to the matrices as mathematical objects.
    task automatic model_step(input logic [5:0] s, input logic [31:0] e);
        logic [31:0] t [2][2];
        int r;
        int c;
        r = int'(s[1]);
        c = int'(s[0]);
        t = mc;
        case (s[5:4])
            2'd0: ma[r][c] = e;
            2'd1: mb[r][c] = e;
            2'd2: begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        case (s[3:0])
                            4'd1: t[i][j] = ma[i][j] + mb[i][j];
                            4'd2: t[i][j] = ma[i][j] - mb[i][j];
                            4'd3: t[i][j] = ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j];
                            4'd4: t[i][j] = ma[i][j] * mb[i][j];
                            4'd5: t[i][j] = ma[j][i];
                            4'd6: t[i][j] = e * ma[i][j];
                            4'd7: t[i][j] = ma[i][j] & mb[i][j];
                            4'd8: t[i][j] = ma[i][j] | mb[i][j];
                            4'd9: t[i][j] = ma[i][j] ^ mb[i][j];
                            default: t[i][j] = mc[i][j];
                        endcase
                mc = t;
            end
            default: begin
                case (s[3:2])
                    2'd0: mout = mc[r][c];
                    2'd1: mout = ma[r][c];
                    2'd2: mout = mb[r][c];
                    default: mout = '0;
                endcase
            end
        endcase
    endtask

    // Compare process: advance the model at each edge, check eleOut just after.
    always @(posedge clk) begin
        if (reset === 1'b1) model_step(bus.sel, bus.ele_in);
        else model_clear();
        #1;
        check("eleOut_model", bus.ele_out, mout);
    end

    // Asynchronous reset: contents drop immediately, no clock needed.
    always @(negedge reset) begin
        if (started) begin
            model_clear();
            #1;
            check("eleOut_async_reset", bus.ele_out, 32'h0);
        end
    end

    task automatic issue(input logic [5:0] s, input logic [31:0] e);
        @(negedge clk);
        bus.sel    = s;
        bus.ele_in = e;
        txn++;
        $display("txn %0d sel=%b eleIn=%h", txn, s, e);
    endtask

    task automatic rd_expect(input string name, input logic [5:0] s, input logic [31:0] exp);
        issue(s, 32'h0);
        @(posedge clk);
        #1;
        check(name, bus.ele_out, exp);
    endtask

    task automatic load_ab();
        for (int i = 0; i < 4; i++) issue(6'(i), 32'(i + 1));
        for (int i = 0; i < 4; i++) issue(6'(16 + i), 32'(i + 5));
    endtask

    initial begin
        model_clear();
        reset      = 1'b0;
        bus.sel    = 6'b100000;
        bus.ele_in = '0;
        // A write while reset is low must be ignored.
        issue(6'b000000, 32'd99);
        repeat (5) @(posedge clk);
        #1;
        check("reset_hold", bus.ele_out, 32'h0);
        @(negedge clk);
        bus.sel = 6'b100000;
        reset   = 1'b1;
        started = 1'b1;

        rd_expect("rst_C0", 6'b110000, 32'h0);
        rd_expect("rst_A3", 6'b110111, 32'h0);
        rd_expect("rst_B1", 6'b111001, 32'h0);
        rd_expect("rst_A0_ignored_write", 6'b110100, 32'h0);

        for (int i = 0; i < 4; i++) issue(6'(i), 32'(i + 1));
        issue(6'd18, 32'd30);
        rd_expect("B2_read", 6'b111010, 32'd30);
        rd_expect("A3_read", 6'b110111, 32'd4);

        load_ab();
        issue(6'b100011, 32'h0);
        rd_expect("mmul_C0", 6'b110000, 32'd19);
        rd_expect("mmul_C1", 6'b110001, 32'd22);
        rd_expect("mmul_C2", 6'b110010, 32'd43);
        rd_expect("mmul_C3", 6'b110011, 32'd50);
        issue(6'b100001, 32'h0);
        rd_expect("add_C0", 6'b110000, 32'd6);
        rd_expect("add_C3", 6'b110011, 32'd12);
        issue(6'b100010, 32'h0);
        rd_expect("sub_C1", 6'b110001, 32'hFFFFFFFC);
        rd_expect("sub_C2", 6'b110010, 32'hFFFFFFFC);

        issue(6'b000000, 32'hFFFFFFFF);
        issue(6'b010000, 32'd1);
        issue(6'b100001, 32'h0);
        rd_expect("wrap_add_C0", 6'b110000, 32'h0);
        issue(6'b100110, 32'd2);
        rd_expect("wrap_smul_C0", 6'b110000, 32'hFFFFFFFE);
        rd_expect("smul_C3", 6'b110011, 32'd8);

        issue(6'b000000, 32'd1);
        issue(6'b100101, 32'h0);
        rd_expect("trn_C1", 6'b110001, 32'd3);
        issue(6'b100000, 32'h0);
        rd_expect("nop0_C2", 6'b110010, 32'd2);
        issue(6'b101100, 32'd77);
        rd_expect("nop12_C0", 6'b110000, 32'd1);
        rd_expect("nop12_C3", 6'b110011, 32'd4);
        rd_expect("read_zero", 6'b111110, 32'h0);

        for (int n = 0; n < 300; n++)
            issue(6'($urandom), $urandom);

        issue(6'b000001, 32'd7);
        rd_expect("pre_async_A1", 6'b110101, 32'd7);
        #3;
        reset = 1'b0;
        #1;
        check("async_eleOut", bus.ele_out, 32'h0);
        bus.sel = 6'b100000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        rd_expect("post_rst_A1", 6'b110101, 32'h0);
        rd_expect("post_rst_B0", 6'b111000, 32'h0);
        rd_expect("post_rst_C0", 6'b110000, 32'h0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_matrix_top.md
ALU_MATRIX_TOP -- requirements
Module: alu_matrix_top

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the element width in bits; all behaviour below is stated for DW=32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sel, input, 6 bits: command word, sampled every rising clk edge.
REQ-005 The block SHALL have port eleIn, input, DW bits: element data, or scalar operand for a scalar-multiply command.
REQ-006 The block SHALL have port eleOut, output, DW bits: registered element read-back.

Function
REQ-007 The block SHALL hold three 2x2 element matrices A, B and C, each element DW bits wide; the element index is idx = row*2 + col, giving indices 0..3.
REQ-008 The command class SHALL be decoded from sel[5:4]:
- 00 = write A
- 01 = write B
- 10 = compute
- 11 = read
REQ-009 A write-A command SHALL set A[sel[1:0]] <= eleIn at the edge; sel[3:2] is ignored; B, C and eleOut are unchanged.
REQ-010 A write-B command SHALL set B[sel[1:0]] <= eleIn; for example sel=18 (6'b010010), eleIn=30 writes B[2] (row 1, col 0) = 30.
REQ-011 A compute command SHALL write the result into all four elements of C at the edge, selected by opcode sel[3:0]:
- 0 NOP (C unchanged)
- 1 C=A+B
- 2 C=A-B
- 3 C=A×B (matrix product)
- 4 C=A∘B (element-wise product)
- 5 C=transpose(A)
- 6 C=eleIn·A (scalar multiply)
- 7 C=A&B
- 8 C=A|B
- 9 C=A^B
- 10..15 NOP
REQ-012 All arithmetic SHALL be two's-complement modulo 2^DW: sums and products are truncated to the low DW bits, and matrix-product partial sums wrap the same way.
REQ-013 A compute command SHALL read A and B as they were before the edge, and SHALL leave A, B and eleOut unchanged.
REQ-014 A read command SHALL set eleOut <= M[sel[1:0]], with the source M chosen by sel[3:2]: 00 = C, 01 = A, 10 = B, 11 = constant 0.
REQ-015 Read latency SHALL be one clock: eleOut is valid after the edge that samples the read command, and holds its value until the next read command or reset.
REQ-016 A read in cycle N+1 SHALL return the C computed in cycle N, and a read of A or B SHALL return any write made in an earlier cycle; there is no same-cycle bypass.
REQ-017 The block SHALL have no handshake and no stall: exactly one command executes per clock, and the block is always ready.
REQ-018 eleIn SHALL be ignored for every command except write-A, write-B and compute opcode 6.

Reset
REQ-019 While reset is low, A, B, C and eleOut SHALL clear to 0 immediately, independent of clk.
REQ-020 A command presented while reset is low SHALL have no effect.
REQ-021 The first command SHALL be taken at the first rising edge after reset deasserts.
REQ-022 A reset asserted mid-sequence SHALL discard all matrix contents.

Structure
REQ-023 A shared package SHALL hold:
- class encodings (CLS_WRA, CLS_WRB, CLS_OP, CLS_RD)
- opcode constants (OP_NOP … OP_XOR)
- read-source codes
- a 2x2 matrix typedef of DW-bit elements
REQ-024 The datapath SHALL be one purely combinational sub-module, alu_matrix_core (inputs A, B, scalar, opcode; output next-C); the register file and decode SHALL live in alu_matrix_top.

Verification
REQ-025 Reset: hold reset low for 5 clocks, then issue reads of C[0], A[3] and B[1] -> eleOut = 0 each time.
REQ-026 Load and read: write A = {1,2,3,4} and B[2] = 30 (sel=18, eleIn=30), then read B[2] (sel=6'b111010) -> eleOut = 30 one clock later.
REQ-027 Arithmetic: A = {1,2,3,4}, B = {5,6,7,8}:
- op 3 (matrix product), read C -> {19,22,43,50}
- op 1 (add), read C -> {6,8,10,12}
- op 2 (subtract), read C -> {-4,-4,-4,-4}, i.e. 32'hFFFFFFFC
REQ-028 Wrap: A[0] = 32'hFFFFFFFF, B[0] = 1, op 1 -> C[0] = 0; then op 6 with eleIn=2 -> C[0] = 32'hFFFFFFFE.
REQ-029 Transpose and NOP: A = {1,2,3,4}, op 5 -> C = {1,3,2,4}; then op 0 or op 12 leaves C unchanged; a read with sel[3:2] = 11 returns 0.
REQ-030 Asynchronous reset: assert reset between clock edges after loading data -> eleOut goes to 0 before the next edge, and all subsequent reads return 0.
